// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two-source round-robin arbiter for the common data bus.
// The ALU and the load/store buffer each feed a circular FIFO, and one
// registered broadcast per cycle is driven from the granted FIFO head.
// Optional feature macro: CDB_BYPASS_EN. When it is defined, a result offered
// to an empty FIFO may be granted straight onto the bus in the same cycle.
module cdb_arbiter #(
  parameter int ROB_WIDTH  = 4,
  parameter int FIFO_WIDTH = 2
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 clearIn,
  input  logic                 rsValid,
  input  logic [ROB_WIDTH-1:0] rsRobIndex,
  input  logic [31:0]          rsVal,
  output logic                 rsReady,
  input  logic                 lsbValid,
  input  logic [ROB_WIDTH-1:0] lsbRobIndex,
  input  logic [31:0]          lsbVal,
  output logic                 lsbReady,
  output logic                 cdbValid,
  output logic [ROB_WIDTH-1:0] cdbRobIndex,
  output logic [31:0]          cdbVal,
  output logic                 cdbFromLsb
);

  localparam int DEPTH   = 1 << FIFO_WIDTH;
  localparam int ENTRY_W = ROB_WIDTH + 32;
  localparam logic [FIFO_WIDTH:0]   CNT_FULL = (FIFO_WIDTH + 1)'(DEPTH);
  localparam logic [FIFO_WIDTH:0]   CNT_ONE  = (FIFO_WIDTH + 1)'(1);
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE  = (FIFO_WIDTH)'(1);

  logic [ENTRY_W-1:0]    rs_mem_q  [DEPTH];
  logic [ENTRY_W-1:0]    lsb_mem_q [DEPTH];

  logic [FIFO_WIDTH-1:0] rs_head_q, rs_head_d, rs_tail_q, rs_tail_d;
  logic [FIFO_WIDTH-1:0] lsb_head_q, lsb_head_d, lsb_tail_q, lsb_tail_d;
  logic [FIFO_WIDTH:0]   rs_count_q, rs_count_d, lsb_count_q, lsb_count_d;
  logic                  last_lsb_q, last_lsb_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [ROB_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [31:0]           cdb_val_q, cdb_val_d;
  logic                  cdb_from_lsb_q, cdb_from_lsb_d;

  logic rs_empty, rs_req, rs_gnt, rs_bypass, rs_push_fifo, rs_pop, rs_wr_en;
  logic lsb_empty, lsb_req, lsb_gnt, lsb_bypass, lsb_push_fifo, lsb_pop, lsb_wr_en;

  // Ready depends only on registered counts, so a full FIFO stays not-ready
  // even when it is being popped this cycle.
  assign rsReady     = (rs_count_q != CNT_FULL);
  assign lsbReady    = (lsb_count_q != CNT_FULL);
  assign cdbValid    = cdb_valid_q;
  assign cdbRobIndex = cdb_tag_q;
  assign cdbVal      = cdb_val_q;
  assign cdbFromLsb  = cdb_from_lsb_q;

  // Requests, round-robin grant, and which pushes/pops actually touch a FIFO.
  always_comb begin
    rs_empty  = (rs_count_q == '0);
    lsb_empty = (lsb_count_q == '0);
`ifdef CDB_BYPASS_EN
    rs_req  = !rs_empty || rsValid;
    lsb_req = !lsb_empty || lsbValid;
`else
    rs_req  = !rs_empty;
    lsb_req = !lsb_empty;
`endif
    rs_gnt  = rs_req && (!lsb_req || last_lsb_q);
    lsb_gnt = lsb_req && (!rs_req || !last_lsb_q);
`ifdef CDB_BYPASS_EN
    rs_bypass  = rs_gnt && rs_empty;
    lsb_bypass = lsb_gnt && lsb_empty;
`else
    rs_bypass  = 1'b0;
    lsb_bypass = 1'b0;
`endif
    rs_pop        = rs_gnt && !rs_empty;
    lsb_pop       = lsb_gnt && !lsb_empty;
    rs_push_fifo  = rsValid && rsReady && !rs_bypass;
    lsb_push_fifo = lsbValid && lsbReady && !lsb_bypass;
    rs_wr_en      = rs_push_fifo && !clearIn;
    lsb_wr_en     = lsb_push_fifo && !clearIn;
  end

  // Next-state for pointers, counts, grant history and the broadcast registers.
  always_comb begin
    rs_head_d      = rs_head_q;
    rs_tail_d      = rs_tail_q;
    rs_count_d     = rs_count_q;
    lsb_head_d     = lsb_head_q;
    lsb_tail_d     = lsb_tail_q;
    lsb_count_d    = lsb_count_q;
    last_lsb_d     = last_lsb_q;
    cdb_valid_d    = rs_gnt || lsb_gnt;
    cdb_tag_d      = cdb_tag_q;
    cdb_val_d      = cdb_val_q;
    cdb_from_lsb_d = cdb_from_lsb_q;

    if (rs_push_fifo) rs_tail_d = rs_tail_q + PTR_ONE;
    if (rs_pop)       rs_head_d = rs_head_q + PTR_ONE;
    if (rs_push_fifo && !rs_pop)      rs_count_d = rs_count_q + CNT_ONE;
    else if (!rs_push_fifo && rs_pop) rs_count_d = rs_count_q - CNT_ONE;

    if (lsb_push_fifo) lsb_tail_d = lsb_tail_q + PTR_ONE;
    if (lsb_pop)       lsb_head_d = lsb_head_q + PTR_ONE;
    if (lsb_push_fifo && !lsb_pop)      lsb_count_d = lsb_count_q + CNT_ONE;
    else if (!lsb_push_fifo && lsb_pop) lsb_count_d = lsb_count_q - CNT_ONE;

    if (rs_gnt) begin
      {cdb_tag_d, cdb_val_d} = rs_bypass ? {rsRobIndex, rsVal} : rs_mem_q[rs_head_q];
      cdb_from_lsb_d = 1'b0;
      last_lsb_d     = 1'b0;
    end else if (lsb_gnt) begin
      {cdb_tag_d, cdb_val_d} = lsb_bypass ? {lsbRobIndex, lsbVal} : lsb_mem_q[lsb_head_q];
      cdb_from_lsb_d = 1'b1;
      last_lsb_d     = 1'b1;
    end

    if (clearIn) begin
      rs_head_d      = '0;
      rs_tail_d      = '0;
      rs_count_d     = '0;
      lsb_head_d     = '0;
      lsb_tail_d     = '0;
      lsb_count_d    = '0;
      last_lsb_d     = 1'b1;
      cdb_valid_d    = 1'b0;
      cdb_tag_d      = cdb_tag_q;
      cdb_val_d      = cdb_val_q;
      cdb_from_lsb_d = cdb_from_lsb_q;
    end
  end

  // Control and broadcast registers; reset matches the flushed state.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      rs_head_q      <= '0;
      rs_tail_q      <= '0;
      rs_count_q     <= '0;
      lsb_head_q     <= '0;
      lsb_tail_q     <= '0;
      lsb_count_q    <= '0;
      last_lsb_q     <= 1'b1;
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_val_q      <= '0;
      cdb_from_lsb_q <= 1'b0;
    end else begin
      rs_head_q      <= rs_head_d;
      rs_tail_q      <= rs_tail_d;
      rs_count_q     <= rs_count_d;
      lsb_head_q     <= lsb_head_d;
      lsb_tail_q     <= lsb_tail_d;
      lsb_count_q    <= lsb_count_d;
      last_lsb_q     <= last_lsb_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_val_q      <= cdb_val_d;
      cdb_from_lsb_q <= cdb_from_lsb_d;
    end
  end

  // FIFO storage; contents are only meaningful between head and tail.
  always_ff @(posedge clockIn) begin
    if (rs_wr_en)  rs_mem_q[rs_tail_q]   <= {rsRobIndex, rsVal};
    if (lsb_wr_en) lsb_mem_q[lsb_tail_q] <= {lsbRobIndex, lsbVal};
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios for the CDB arbiter (default build).
module tb_cdb_arbiter;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b1;
  logic        clearIn = 1'b0;
  logic        rsValid = 1'b0;
  logic [3:0]  rsRobIndex = '0;
  logic [31:0] rsVal = '0;
  logic        rsReady;
  logic        lsbValid = 1'b0;
  logic [3:0]  lsbRobIndex = '0;
  logic [31:0] lsbVal = '0;
  logic        lsbReady;
  logic        cdbValid;
  logic [3:0]  cdbRobIndex;
  logic [31:0] cdbVal;
  logic        cdbFromLsb;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.ROB_WIDTH(4), .FIFO_WIDTH(2)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .clearIn(clearIn),
    .rsValid(rsValid), .rsRobIndex(rsRobIndex), .rsVal(rsVal), .rsReady(rsReady),
    .lsbValid(lsbValid), .lsbRobIndex(lsbRobIndex), .lsbVal(lsbVal), .lsbReady(lsbReady),
    .cdbValid(cdbValid), .cdbRobIndex(cdbRobIndex), .cdbVal(cdbVal), .cdbFromLsb(cdbFromLsb)
  );

  always #5 clockIn = ~clockIn;

  task automatic step();
    @(posedge clockIn);
    #1;
  endtask

  task automatic do_reset();
    rsValid = 1'b0; lsbValid = 1'b0; clearIn = 1'b0;
    resetIn = 1'b1;
    #2;
    resetIn = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rsReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_rsReady got %b expected 1", rsReady); end
    checks++; if (lsbReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_lsbReady got %b expected 1", lsbReady); end
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cdbValid got %b expected 0", cdbValid); end
    checks++; if (cdbRobIndex !== 4'd0) begin errors++; $display("[TB] FAIL reset_cdbRobIndex got %h expected 0", cdbRobIndex); end
    checks++; if (cdbVal !== 32'd0) begin errors++; $display("[TB] FAIL reset_cdbVal got %h expected 0", cdbVal); end
    checks++; if (cdbFromLsb !== 1'b0) begin errors++; $display("[TB] FAIL reset_cdbFromLsb got %b expected 0", cdbFromLsb); end
    #1;
    resetIn = 1'b0;
    step();
  endtask

  task automatic test_single_alu();
    do_reset();
    rsValid = 1'b1; rsRobIndex = 4'd3; rsVal = 32'h1234;
    step();
    rsValid = 1'b0;
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL single_t1_valid got %b expected 0", cdbValid); end
    step();
    checks++; if (cdbValid !== 1'b1) begin errors++; $display("[TB] FAIL single_t2_valid got %b expected 1", cdbValid); end
    checks++; if (cdbRobIndex !== 4'd3) begin errors++; $display("[TB] FAIL single_tag got %h expected 3", cdbRobIndex); end
    checks++; if (cdbVal !== 32'h1234) begin errors++; $display("[TB] FAIL single_val got %h expected 1234", cdbVal); end
    checks++; if (cdbFromLsb !== 1'b0) begin errors++; $display("[TB] FAIL single_src got %b expected 0", cdbFromLsb); end
    step();
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse got %b expected 0", cdbValid); end
    checks++; if (cdbRobIndex !== 4'd3) begin errors++; $display("[TB] FAIL single_hold_tag got %h expected 3", cdbRobIndex); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    rsValid = 1'b1; rsRobIndex = 4'd1; rsVal = 32'h1111;
    lsbValid = 1'b1; lsbRobIndex = 4'd2; lsbVal = 32'h2222;
    step();
    rsValid = 1'b0; lsbValid = 1'b0;
    step();
    checks++; if ({cdbValid, cdbRobIndex, cdbFromLsb} !== {1'b1, 4'd1, 1'b0})
      begin errors++; $display("[TB] FAIL simul_first got v=%b tag=%h lsb=%b expected v=1 tag=1 lsb=0", cdbValid, cdbRobIndex, cdbFromLsb); end
    checks++; if (cdbVal !== 32'h1111) begin errors++; $display("[TB] FAIL simul_first_val got %h expected 1111", cdbVal); end
    step();
    checks++; if ({cdbValid, cdbRobIndex, cdbFromLsb} !== {1'b1, 4'd2, 1'b1})
      begin errors++; $display("[TB] FAIL simul_second got v=%b tag=%h lsb=%b expected v=1 tag=2 lsb=1", cdbValid, cdbRobIndex, cdbFromLsb); end
    checks++; if (cdbVal !== 32'h2222) begin errors++; $display("[TB] FAIL simul_second_val got %h expected 2222", cdbVal); end
    step();
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL simul_idle got %b expected 0", cdbValid); end
  endtask

  // Both sources offer every cycle for 10 cycles; a queue model tracks
  // which offers are accepted and the expected alternating broadcast order.
  task automatic test_saturation();
    int qa[$];
    int ql[$];
    int na = 0;
    int nl = 0;
    int n_bc = 0;
    int exp_v;
    bit last_lsb = 1'b1;
    bit a_rdy, l_rdy, ga, gl, offer;
    bit saw_a_full = 1'b0;
    bit saw_l_full = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      offer = (cyc < 10);
      a_rdy = (qa.size() != 4);
      l_rdy = (ql.size() != 4);
      checks++; if (rsReady !== a_rdy) begin errors++; $display("[TB] FAIL sat_rsReady cyc %0d got %b expected %b", cyc, rsReady, a_rdy); end
      checks++; if (lsbReady !== l_rdy) begin errors++; $display("[TB] FAIL sat_lsbReady cyc %0d got %b expected %b", cyc, lsbReady, l_rdy); end
      if (rsReady === 1'b0) saw_a_full = 1'b1;
      if (lsbReady === 1'b0) saw_l_full = 1'b1;
      rsValid = offer; rsRobIndex = 4'(na); rsVal = 32'hA000_0000 + 32'(na);
      lsbValid = offer; lsbRobIndex = 4'(nl); lsbVal = 32'hB000_0000 + 32'(nl);
      ga = (qa.size() != 0) && ((ql.size() == 0) || last_lsb);
      gl = (ql.size() != 0) && ((qa.size() == 0) || !last_lsb);
      exp_v = 0;
      step();
      if (ga) begin exp_v = qa.pop_front(); last_lsb = 1'b0; end
      if (gl) begin exp_v = ql.pop_front(); last_lsb = 1'b1; end
      if (offer && a_rdy) begin qa.push_back(32'hA000_0000 + na); na++; end
      if (offer && l_rdy) begin ql.push_back(32'hB000_0000 + nl); nl++; end
      if (cdbValid === 1'b1) n_bc++;
      checks++; if (cdbValid !== (ga | gl)) begin errors++; $display("[TB] FAIL sat_valid cyc %0d got %b expected %b", cyc, cdbValid, ga | gl); end
      if (ga | gl) begin
        checks++; if (cdbVal !== 32'(exp_v)) begin errors++; $display("[TB] FAIL sat_val cyc %0d got %h expected %h", cyc, cdbVal, 32'(exp_v)); end
        checks++; if (cdbRobIndex !== 4'(exp_v)) begin errors++; $display("[TB] FAIL sat_tag cyc %0d got %h expected %h", cyc, cdbRobIndex, 4'(exp_v)); end
        checks++; if (cdbFromLsb !== gl) begin errors++; $display("[TB] FAIL sat_src cyc %0d got %b expected %b", cyc, cdbFromLsb, gl); end
      end
    end
    rsValid = 1'b0; lsbValid = 1'b0;
    checks++; if (saw_a_full !== 1'b1) begin errors++; $display("[TB] FAIL sat_rs_full got %b expected 1", saw_a_full); end
    checks++; if (saw_l_full !== 1'b1) begin errors++; $display("[TB] FAIL sat_lsb_full got %b expected 1", saw_l_full); end
    checks++; if (n_bc !== 16) begin errors++; $display("[TB] FAIL sat_broadcasts got %0d expected 16", n_bc); end
  endtask

  task automatic test_fifo_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      checks++; if (rsReady !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ready %0d got %b expected 1", i, rsReady); end
      rsValid = 1'b1; rsRobIndex = 4'(i); rsVal = 32'h50 + 32'(i);
      step();
      if (i > 0) begin
        checks++; if ({cdbValid, cdbRobIndex} !== {1'b1, 4'(i - 1)})
          begin errors++; $display("[TB] FAIL wrap_bc %0d got v=%b tag=%h expected v=1 tag=%h", i, cdbValid, cdbRobIndex, 4'(i - 1)); end
      end
    end
    rsValid = 1'b0;
    step();
    checks++; if ({cdbValid, cdbRobIndex, cdbVal} !== {1'b1, 4'd5, 32'h55})
      begin errors++; $display("[TB] FAIL wrap_last got v=%b tag=%h val=%h expected v=1 tag=5 val=55", cdbValid, cdbRobIndex, cdbVal); end
    step();
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_drained got %b expected 0", cdbValid); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rsValid = 1'b1; rsRobIndex = 4'(i); rsVal = 32'hC0 + 32'(i);
      lsbValid = 1'b1; lsbRobIndex = 4'(8 + i); lsbVal = 32'hD0 + 32'(i);
      step();
    end
    rsValid = 1'b0; lsbValid = 1'b0;
    step();
    checks++; if ({cdbValid, cdbRobIndex, cdbFromLsb} !== {1'b1, 4'd2, 1'b0})
      begin errors++; $display("[TB] FAIL flush_pre got v=%b tag=%h lsb=%b expected v=1 tag=2 lsb=0", cdbValid, cdbRobIndex, cdbFromLsb); end
    clearIn = 1'b1;
    rsValid = 1'b1; rsRobIndex = 4'd14; rsVal = 32'hEE;
    lsbValid = 1'b1; lsbRobIndex = 4'd15; lsbVal = 32'hFF;
    step();
    clearIn = 1'b0; rsValid = 1'b0; lsbValid = 1'b0;
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b expected 0", cdbValid); end
    checks++; if ({rsReady, lsbReady} !== 2'b11) begin errors++; $display("[TB] FAIL flush_ready got %b expected 11", {rsReady, lsbReady}); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_stale %0d got v=%b tag=%h expected v=0", i, cdbValid, cdbRobIndex); end
    end
    rsValid = 1'b1; rsRobIndex = 4'd9; rsVal = 32'h99;
    lsbValid = 1'b1; lsbRobIndex = 4'd10; lsbVal = 32'hAA;
    step();
    rsValid = 1'b0; lsbValid = 1'b0;
    step();
    checks++; if ({cdbValid, cdbRobIndex, cdbFromLsb} !== {1'b1, 4'd9, 1'b0})
      begin errors++; $display("[TB] FAIL flush_alu_first got v=%b tag=%h lsb=%b expected v=1 tag=9 lsb=0", cdbValid, cdbRobIndex, cdbFromLsb); end
    step();
    checks++; if ({cdbValid, cdbRobIndex, cdbFromLsb} !== {1'b1, 4'd10, 1'b1})
      begin errors++; $display("[TB] FAIL flush_lsb_next got v=%b tag=%h lsb=%b expected v=1 tag=a lsb=1", cdbValid, cdbRobIndex, cdbFromLsb); end
  endtask

  task automatic test_async_reset();
    do_reset();
    rsValid = 1'b1; rsRobIndex = 4'd7; rsVal = 32'hDEAD_BEEF;
    lsbValid = 1'b1; lsbRobIndex = 4'd6; lsbVal = 32'h66;
    step();
    rsValid = 1'b0; lsbValid = 1'b0;
    step();
    checks++; if ({cdbValid, cdbRobIndex} !== {1'b1, 4'd7})
      begin errors++; $display("[TB] FAIL arst_pre got v=%b tag=%h expected v=1 tag=7", cdbValid, cdbRobIndex); end
    #2;
    resetIn = 1'b1;
    #1;
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid got %b expected 0", cdbValid); end
    checks++; if (cdbRobIndex !== 4'd0) begin errors++; $display("[TB] FAIL arst_tag got %h expected 0", cdbRobIndex); end
    checks++; if (cdbVal !== 32'd0) begin errors++; $display("[TB] FAIL arst_val got %h expected 0", cdbVal); end
    #2;
    resetIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (cdbValid !== 1'b0) begin errors++; $display("[TB] FAIL arst_empty %0d got v=%b tag=%h expected v=0", i, cdbValid, cdbRobIndex); end
      checks++; if ({rsReady, lsbReady} !== 2'b11) begin errors++; $display("[TB] FAIL arst_ready %0d got %b expected 11", i, {rsReady, lsbReady}); end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_saturation();
    test_fifo_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
